// File: rtl/md_frame_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : md_frame_streamer
//  Purpose  : Captures an unpacked 2-D frame on LOAD. It keeps a packed
//             snapshot of that frame and streams the elements out in
//             row-major order under a valid/ready handshake. Alongside the
//             stream it carries a set of 1-bit lanes through a fixed-depth
//             delay pipeline.
//  Ports    :
//    clk_i        - clock, all state updates on the rising edge
//    rst_ni       - asynchronous active-low reset
//    load_i       - request to capture frame a_i
//    a_i          - input frame, unpacked [0:ROWS-1][0:COLS-1] of W bits
//    busy_o       - high while streaming
//    out_valid_o  - out_data_o holds a valid element
//    out_ready_i  - consumer accepts the current element
//    out_data_o   - current element
//    out_row_o    - row index of the current element
//    out_col_o    - column index of the current element
//    out_last_o   - current element is (ROWS-1, COLS-1)
//    snap_o       - packed copy of the last captured frame
//    done_cnt_o   - completed-frame count, wraps 0xFFFF -> 0
//    e_i          - lane inputs, unpacked [LANES-1:0]
//    f_o          - lane outputs, e_i delayed DEPTH cycles
//  Revision : 1.0 - initial release
// ============================================================================
module md_frame_streamer #(
  parameter int W     = 8,
  parameter int ROWS  = 3,
  parameter int COLS  = 4,
  parameter int LANES = 4,
  parameter int DEPTH = 2,
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 load_i,
  input  logic [W-1:0]                         a_i [0:ROWS-1][0:COLS-1],
  output logic                                 busy_o,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic [W-1:0]                         out_data_o,
  output logic [RW-1:0]                        out_row_o,
  output logic [CW-1:0]                        out_col_o,
  output logic                                 out_last_o,
  output logic [ROWS-1:0][COLS-1:0][W-1:0]     snap_o,
  output logic [15:0]                          done_cnt_o,
  input  logic                                 e_i [LANES-1:0],
  output logic                                 f_o [LANES-1:0]
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  localparam logic [RW-1:0] C_LAST_ROW = RW'(ROWS - 1);
  localparam logic [CW-1:0] C_LAST_COL = CW'(COLS - 1);

  logic [0:0]                       state_q, state_d;
  logic [RW-1:0]                    row_q, row_d;
  logic [CW-1:0]                    col_q, col_d;
  logic [15:0]                      done_q, done_d;
  // The frame store and the snapshot always hold the same captured data, so
  // one register set serves both as the streaming source and as snap_o.
  logic [ROWS-1:0][COLS-1:0][W-1:0] snap_q, snap_d;

  logic w_streaming;
  logic w_at_end;
  logic w_xfer;
  logic w_capture;

  assign w_streaming = (state_q == S_STREAM);
  assign w_at_end    = (row_q == C_LAST_ROW) && (col_q == C_LAST_COL);
  assign w_xfer      = w_streaming && out_ready_i;

  // --------------------------------------------------------------------------
  // Stream control
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    done_d    = done_q;
    w_capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_i) begin
          w_capture = 1'b1;
          row_d     = '0;
          col_d     = '0;
          state_d   = S_STREAM;
        end
      end
      S_STREAM: begin
        if (w_xfer) begin
          if (w_at_end) begin
            done_d = done_q + 16'd1;
            row_d  = '0;
            col_d  = '0;
            // A LOAD coinciding with the final transfer chains straight into
            // the next frame; otherwise LOAD is ignored while streaming.
            if (load_i) begin
              w_capture = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else if (col_q == C_LAST_COL) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    snap_d = snap_q;
    if (w_capture) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          snap_d[r][c] = a_i[r][c];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      done_q  <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      done_q  <= done_d;
      snap_q  <= snap_d;
    end
  end

  assign busy_o      = w_streaming;
  assign out_valid_o = w_streaming;
  assign out_last_o  = w_streaming && w_at_end;
  assign out_data_o  = snap_q[row_q][col_q];
  assign out_row_o   = row_q;
  assign out_col_o   = col_q;
  assign snap_o      = snap_q;
  assign done_cnt_o  = done_q;

  // --------------------------------------------------------------------------
  // Lane delay pipeline, independent of the stream
  // --------------------------------------------------------------------------
  logic [LANES-1:0] w_e_vec;
  logic [LANES-1:0] lane_q [DEPTH];

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane_io
      assign w_e_vec[i] = e_i[i];
      assign f_o[i]     = lane_q[DEPTH-1][i];
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < DEPTH; k++) begin
        lane_q[k] <= '0;
      end
    end else begin
      lane_q[0] <= w_e_vec;
      for (int k = 1; k < DEPTH; k++) begin
        lane_q[k] <= lane_q[k-1];
      end
    end
  end

endmodule
`default_nettype wire
